// File: rtl/video_pkg.sv
// Shared video-stream definitions: frame generator FSM encoding and the ramp line step.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LGAP = 2'd2,
    ST_FGAP = 2'd3
  } state_t;

  // Each line of the test ramp starts this far above the previous one.
  localparam int LINE_STEP = 10;

endpackage

// File: rtl/axis_pix_counter.sv
// Pixel/line position counters for the frame generator, with wrap at width-1 / height-1
// and the coordinates of the following beat.
module axis_pix_counter #(
  parameter int C_RESO_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [C_RESO_WIDTH-1:0] width,
  input  logic [C_RESO_WIDTH-1:0] height,
  output logic [C_RESO_WIDTH-1:0] pix,
  output logic [C_RESO_WIDTH-1:0] line,
  output logic [C_RESO_WIDTH-1:0] nxt_pix,
  output logic [C_RESO_WIDTH-1:0] nxt_line,
  output logic                    last_pix,
  output logic                    last_line
);

  localparam logic [C_RESO_WIDTH-1:0] ONE = C_RESO_WIDTH'(1);

  logic [C_RESO_WIDTH-1:0] pix_reg;
  logic [C_RESO_WIDTH-1:0] line_reg;

  assign pix       = pix_reg;
  assign line      = line_reg;
  assign last_pix  = (pix_reg == width - ONE);
  assign last_line = (line_reg == height - ONE);

  always_comb begin
    nxt_pix  = pix_reg + ONE;
    nxt_line = line_reg;
    if (last_pix) begin
      nxt_pix  = '0;
      nxt_line = last_line ? '0 : line_reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_reg  <= '0;
      line_reg <= '0;
    end else if (clear) begin
      pix_reg  <= '0;
      line_reg <= '0;
    end else if (advance) begin
      pix_reg  <= nxt_pix;
      line_reg <= nxt_line;
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI4-Stream ramp frame source with programmable size, frame count and inter-frame gap.
// Define AXIS_FRAME_GEN_LINE_GAP_EN to insert C_LINE_GAP idle cycles after each non-final line.
module axis_frame_gen
  import video_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_RESO_WIDTH  = 10,
  parameter int C_FRAME_GAP   = 4,
  parameter int C_LINE_GAP    = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic                     stop,
  input  logic [C_RESO_WIDTH-1:0]  ori_width,
  input  logic [C_RESO_WIDTH-1:0]  ori_height,
  input  logic [C_RESO_WIDTH-1:0]  frame_num,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready
);

  localparam logic [C_RESO_WIDTH-1:0] ONE = C_RESO_WIDTH'(1);
  localparam int PROD_W  = C_RESO_WIDTH + 4;
  localparam int GAP_MAX = (C_FRAME_GAP > C_LINE_GAP) ? C_FRAME_GAP : C_LINE_GAP;
  localparam int GAP_W   = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;

`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
  localparam bit LGAP_EN = (C_LINE_GAP > 0);
`else
  localparam bit LGAP_EN = 1'b0;
`endif

  state_t                   state_reg, state_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     tvalid_reg, tvalid_next;
  logic [C_PIXEL_WIDTH-1:0] tdata_reg, tdata_next;
  logic                     tuser_reg, tuser_next;
  logic                     tlast_reg, tlast_next;
  logic [GAP_W-1:0]         gap_reg, gap_next;
  logic [C_RESO_WIDTH-1:0]  width_reg, width_next;
  logic [C_RESO_WIDTH-1:0]  height_reg, height_next;
  logic [C_RESO_WIDTH-1:0]  frames_reg, frames_next;
  logic                     cont_reg, cont_next;
  logic                     stop_reg, stop_next;

  logic                     cnt_clear, cnt_adv;
  logic [C_RESO_WIDTH-1:0]  pix, line, nxt_pix, nxt_line;
  logic                     last_pix, last_line;
  logic [C_RESO_WIDTH-1:0]  pix_sel, line_sel;
  logic [C_PIXEL_WIDTH-1:0] tdata_load;
  logic                     tuser_load, tlast_load;
  logic                     handshake, more_frames, load, drop;

  axis_pix_counter #(.C_RESO_WIDTH(C_RESO_WIDTH)) u_cnt (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (cnt_clear),
    .advance   (cnt_adv),
    .width     (width_reg),
    .height    (height_reg),
    .pix       (pix),
    .line      (line),
    .nxt_pix   (nxt_pix),
    .nxt_line  (nxt_line),
    .last_pix  (last_pix),
    .last_line (last_line)
  );

  // While running the counters hold the beat on the bus; in a gap they already hold the next one.
  assign pix_sel    = (state_reg == ST_RUN) ? nxt_pix  : pix;
  assign line_sel   = (state_reg == ST_RUN) ? nxt_line : line;
  assign tdata_load = C_PIXEL_WIDTH'(PROD_W'(line_sel) * PROD_W'(LINE_STEP) + PROD_W'(pix_sel));
  assign tuser_load = (pix_sel == '0) && (line_sel == '0);
  assign tlast_load = (pix_sel == width_reg - ONE);

  assign handshake   = tvalid_reg && m_axis_tready;
  assign more_frames = !(stop_reg || stop) && (cont_reg || (frames_reg > ONE));

  always_comb begin
    state_next  = state_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    tvalid_next = tvalid_reg;
    tdata_next  = tdata_reg;
    tuser_next  = tuser_reg;
    tlast_next  = tlast_reg;
    gap_next    = gap_reg;
    width_next  = width_reg;
    height_next = height_reg;
    frames_next = frames_reg;
    cont_next   = cont_reg;
    stop_next   = stop_reg | stop;
    cnt_clear   = 1'b0;
    cnt_adv     = 1'b0;
    load        = 1'b0;
    drop        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        stop_next = 1'b0;
        if (start && (ori_width != '0) && (ori_height != '0)) begin
          state_next  = ST_RUN;
          busy_next   = 1'b1;
          width_next  = ori_width;
          height_next = ori_height;
          frames_next = frame_num;
          cont_next   = (frame_num == '0);
          stop_next   = stop;
          cnt_clear   = 1'b1;
          tvalid_next = 1'b1;
          tdata_next  = '0;
          tuser_next  = 1'b1;
          tlast_next  = (ori_width == ONE);
        end
      end
      ST_RUN: begin
        if (handshake) begin
          cnt_adv = 1'b1;
          if (!last_pix) begin
            load = 1'b1;
          end else if (!last_line) begin
            if (LGAP_EN) begin
              state_next = ST_LGAP;
              gap_next   = '0;
              drop       = 1'b1;
            end else begin
              load = 1'b1;
            end
          end else begin
            done_next = 1'b1;
            if (more_frames) begin
              if (!cont_reg) frames_next = frames_reg - ONE;
              if (C_FRAME_GAP > 0) begin
                state_next = ST_FGAP;
                gap_next   = '0;
                drop       = 1'b1;
              end else begin
                load = 1'b1;
              end
            end else begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              stop_next  = 1'b0;
              drop       = 1'b1;
            end
          end
        end
      end
`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
      ST_LGAP: begin
        gap_next = gap_reg + GAP_W'(1);
        if (gap_reg == GAP_W'(C_LINE_GAP - 1)) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end
      end
`endif
      ST_FGAP: begin
        gap_next = gap_reg + GAP_W'(1);
        if (gap_reg == GAP_W'(C_FRAME_GAP - 1)) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (load) begin
      tvalid_next = 1'b1;
      tdata_next  = tdata_load;
      tuser_next  = tuser_load;
      tlast_next  = tlast_load;
    end
    if (drop) begin
      tvalid_next = 1'b0;
      tuser_next  = 1'b0;
      tlast_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tuser_reg  <= 1'b0;
      tlast_reg  <= 1'b0;
      gap_reg    <= '0;
      width_reg  <= '0;
      height_reg <= '0;
      frames_reg <= '0;
      cont_reg   <= 1'b0;
      stop_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      tvalid_reg <= tvalid_next;
      tdata_reg  <= tdata_next;
      tuser_reg  <= tuser_next;
      tlast_reg  <= tlast_next;
      gap_reg    <= gap_next;
      width_reg  <= width_next;
      height_reg <= height_next;
      frames_reg <= frames_next;
      cont_reg   <= cont_next;
      stop_reg   <= stop_next;
    end
  end

  assign busy          = busy_reg;
  assign frame_done    = done_reg;
  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: frame shape, ramp data, gaps, backpressure, stop and reset.
module tb_axis_frame_gen;

  localparam int PW = 8;
  localparam int RW = 10;
  localparam int FG = 4;
`ifdef AXIS_FRAME_GEN_LINE_GAP_EN
  localparam int LG = 2;
`else
  localparam int LG = 0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          tready = 1'b1;
  logic [RW-1:0] ori_width = '0;
  logic [RW-1:0] ori_height = '0;
  logic [RW-1:0] frame_num = '0;
  logic          busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
  logic [PW-1:0] m_axis_tdata;

  always #5 clk = ~clk;

  axis_frame_gen #(
    .C_PIXEL_WIDTH(PW), .C_RESO_WIDTH(RW), .C_FRAME_GAP(FG), .C_LINE_GAP(2)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .ori_width(ori_width), .ori_height(ori_height), .frame_num(frame_num),
    .busy(busy), .frame_done(frame_done),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(tready)
  );

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] b_data [256];
  bit            b_user [256];
  bit            b_last [256];
  int            b_cyc  [256];
  int            nb;
  int            d_cyc  [16];
  int            nd;
  int            busy_last;

  task automatic do_start(input int w, input int h, input int n, input bit with_stop);
    @(negedge clk);
    ori_width  = RW'(w);
    ori_height = RW'(h);
    frame_num  = RW'(n);
    start      = 1'b1;
    stop       = with_stop;
  endtask

  // Runs a fixed number of cycles, logging beats, frame_done pulses and busy; checks stall holding.
  task automatic capture(input int cycles, input bit rnd, input int stop_at);
    bit            stall = 1'b0;
    bit            stop_sent = 1'b0;
    logic [PW-1:0] h_data = '0;
    bit            h_user = 1'b0;
    bit            h_last = 1'b0;
    nb = 0;
    nd = 0;
    busy_last = -1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== h_data ||
            m_axis_tuser !== h_user || m_axis_tlast !== h_last) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got v=%b d=%0d u=%b l=%b want v=1 d=%0d u=%b l=%b",
                   i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, h_data, h_user, h_last);
        end
      end
      if (stop_at >= 0 && !stop_sent && nb >= stop_at) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end else begin
        stop = 1'b0;
      end
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (frame_done === 1'b1 && nd < 16) begin
        d_cyc[nd] = i;
        nd++;
      end
      if (busy === 1'b1) busy_last = i;
      if (m_axis_tvalid === 1'b1 && tready) begin
        if (nb < 256) begin
          b_data[nb] = m_axis_tdata;
          b_user[nb] = m_axis_tuser;
          b_last[nb] = m_axis_tlast;
          b_cyc[nb]  = i;
        end
        nb++;
      end
      stall  = (m_axis_tvalid === 1'b1) && !tready;
      h_data = m_axis_tdata;
      h_user = m_axis_tuser;
      h_last = m_axis_tlast;
    end
    stop = 1'b0;
    tready = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got b=%b fd=%b v=%b u=%b l=%b d=%0d want all 0",
               busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, m_axis_tvalid} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle got b=%b v=%b want 0 0", busy, m_axis_tvalid);
    end
  endtask

  task automatic test_basic_frame;
    int expc;
    do_start(4, 3, 1, 1'b0);
    capture(40, 1'b0, -1);
    checks++;
    if (nb !== 12) begin failures++; $display("FAIL basic_count got=%0d want=12", nb); end
    for (int k = 0; k < 12; k++) begin
      expc = k + LG * (k / 4);
      checks++;
      if (b_data[k] !== PW'((k / 4) * 10 + k % 4) || b_user[k] !== (k == 0) ||
          b_last[k] !== (k % 4 == 3) || b_cyc[k] !== expc) begin
        failures++;
        $display("FAIL basic_beat%0d got d=%0d u=%b l=%b c=%0d want d=%0d u=%b l=%b c=%0d", k,
                 b_data[k], b_user[k], b_last[k], b_cyc[k], (k / 4) * 10 + k % 4, k == 0, k % 4 == 3, expc);
      end
    end
    expc = 11 + LG * 2 + 1;
    checks++;
    if (nd !== 1 || d_cyc[0] !== expc || busy_last !== expc - 1) begin
      failures++;
      $display("FAIL basic_done got n=%0d c=%0d busy_last=%0d want n=1 c=%0d busy_last=%0d",
               nd, d_cyc[0], busy_last, expc, expc - 1);
    end
  endtask

  task automatic test_backpressure;
    do_start(4, 3, 1, 1'b0);
    capture(300, 1'b1, -1);
    checks++;
    if (nb !== 12 || nd !== 1) begin
      failures++;
      $display("FAIL bp_count got beats=%0d done=%0d want 12 1", nb, nd);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (b_data[k] !== PW'((k / 4) * 10 + k % 4) || b_user[k] !== (k == 0) || b_last[k] !== (k % 4 == 3)) begin
        failures++;
        $display("FAIL bp_beat%0d got d=%0d u=%b l=%b want d=%0d u=%b l=%b", k,
                 b_data[k], b_user[k], b_last[k], (k / 4) * 10 + k % 4, k == 0, k % 4 == 3);
      end
    end
  endtask

  task automatic test_frame_gap;
    do_start(1, 1, 2, 1'b0);
    capture(30, 1'b0, -1);
    checks++;
    if (nb !== 2) begin failures++; $display("FAIL gap_count got=%0d want=2", nb); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b_data[k] !== 8'd0 || b_user[k] !== 1'b1 || b_last[k] !== 1'b1) begin
        failures++;
        $display("FAIL gap_beat%0d got d=%0d u=%b l=%b want d=0 u=1 l=1", k, b_data[k], b_user[k], b_last[k]);
      end
    end
    checks++;
    if (b_cyc[1] - b_cyc[0] !== FG + 1) begin
      failures++;
      $display("FAIL gap_idle got=%0d want=%0d", b_cyc[1] - b_cyc[0] - 1, FG);
    end
    checks++;
    if (nd !== 2 || d_cyc[0] !== b_cyc[0] + 1 || d_cyc[1] !== b_cyc[1] + 1 || busy_last !== b_cyc[1]) begin
      failures++;
      $display("FAIL gap_done got n=%0d c0=%0d c1=%0d busy_last=%0d want n=2 c0=%0d c1=%0d busy_last=%0d",
               nd, d_cyc[0], d_cyc[1], busy_last, b_cyc[0] + 1, b_cyc[1] + 1, b_cyc[1]);
    end
  endtask

  task automatic test_wrap_data;
    do_start(2, 30, 1, 1'b0);
    capture(150, 1'b0, -1);
    checks++;
    if (nb !== 60 || b_last[59] !== 1'b1) begin
      failures++;
      $display("FAIL wrap_count got=%0d last=%b want=60 1", nb, b_last[59]);
    end
    checks++;
    if (b_data[51] !== 8'd251 || b_data[52] !== 8'd4 || b_data[53] !== 8'd5 || b_data[59] !== 8'd35) begin
      failures++;
      $display("FAIL wrap_data got %0d %0d %0d %0d want 251 4 5 35", b_data[51], b_data[52], b_data[53], b_data[59]);
    end
  endtask

  task automatic test_zero_size;
    do_start(0, 3, 1, 1'b0);
    capture(10, 1'b0, -1);
    checks++;
    if (nb !== 0 || busy_last !== -1) begin
      failures++;
      $display("FAIL zero_width got beats=%0d busy_last=%0d want 0 -1", nb, busy_last);
    end
    do_start(3, 0, 1, 1'b0);
    capture(10, 1'b0, -1);
    checks++;
    if (nb !== 0 || busy_last !== -1) begin
      failures++;
      $display("FAIL zero_height got beats=%0d busy_last=%0d want 0 -1", nb, busy_last);
    end
  endtask

  task automatic test_stop;
    do_start(2, 2, 0, 1'b0);
    capture(80, 1'b0, 5);
    checks++;
    if (nb !== 8 || nd !== 2 || busy_last !== d_cyc[1] - 1) begin
      failures++;
      $display("FAIL stop_cont got beats=%0d done=%0d busy_last=%0d want 8 2 %0d", nb, nd, busy_last, d_cyc[1] - 1);
    end
    checks++;
    if (b_user[4] !== 1'b1 || b_data[6] !== 8'd10 || b_data[7] !== 8'd11 || b_last[7] !== 1'b1) begin
      failures++;
      $display("FAIL stop_frame2 got u4=%b d6=%0d d7=%0d l7=%b want 1 10 11 1", b_user[4], b_data[6], b_data[7], b_last[7]);
    end
    do_start(2, 2, 0, 1'b1);
    capture(40, 1'b0, -1);
    checks++;
    if (nb !== 4 || nd !== 1) begin
      failures++;
      $display("FAIL start_stop got beats=%0d done=%0d want 4 1", nb, nd);
    end
  endtask

  task automatic test_line_gap;
    int expc;
    do_start(3, 2, 1, 1'b0);
    capture(30, 1'b0, -1);
    checks++;
    if (nb !== 6) begin failures++; $display("FAIL lgap_count got=%0d want=6", nb); end
    for (int k = 0; k < 6; k++) begin
      expc = k + LG * (k / 3);
      checks++;
      if (b_cyc[k] !== expc || b_data[k] !== PW'((k / 3) * 10 + k % 3)) begin
        failures++;
        $display("FAIL lgap_beat%0d got c=%0d d=%0d want c=%0d d=%0d", k, b_cyc[k], b_data[k], expc, (k / 3) * 10 + k % 3);
      end
    end
    checks++;
    if (nd !== 1 || d_cyc[0] !== b_cyc[5] + 1) begin
      failures++;
      $display("FAIL lgap_done got n=%0d c=%0d want 1 %0d", nd, d_cyc[0], b_cyc[5] + 1);
    end
  endtask

  task automatic test_reset_mid;
    do_start(4, 3, 1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre got v=%b b=%b want 1 1", m_axis_tvalid, busy);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== '0) begin
      failures++;
      $display("FAIL midrst_async got b=%b fd=%b v=%b u=%b l=%b d=%0d want all 0",
               busy, frame_done, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata);
    end
    @(negedge clk);
    resetn = 1'b1;
    capture(10, 1'b0, -1);
    checks++;
    if (nb !== 0 || busy_last !== -1) begin
      failures++;
      $display("FAIL midrst_after got beats=%0d busy_last=%0d want 0 -1", nb, busy_last);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_frame_gap();
    test_wrap_data();
    test_zero_size();
    test_stop();
    test_line_gap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
